// File: rtl/psram_wb_arb_if.sv
// psram_wb_arb_if: one Wishbone B4 classic bus segment (32-bit address,
// 16-bit data) as used around the PSRAM arbiter.
//   master modport : drives adr/dat_w/sel/we/cyc/stb, receives dat_r/ack/err
//   slave modport  : receives adr/dat_w/sel/we/cyc/stb, drives dat_r/ack/err
// The arbiter sits on the slave side of each CPU master bus and on the
// master side of the PSRAM bus (whose err line it never uses).
interface psram_wb_arb_if;
    logic [31:0] adr;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic [1:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/psram_wb_arb.sv
// psram_wb_arb: two-master Wishbone arbiter in front of the single 16-bit
// asynchronous PSRAM slave port.
//   clk_i, rst_i : system clock, synchronous active-high reset
//   m0           : master 0 bus (typically load/store), slave modport
//   m1           : master 1 bus (typically instruction fetch), slave modport
//   s            : PSRAM slave bus, master modport (s.err is not used)
// The grant is registered and held for the owner's whole cyc. A per-transfer
// watchdog answers with a one-cycle err if the slave does not ack within
// TIMEOUT strobed cycles, after which the owner is drained until it drops cyc.
// Optional feature macro PSRAM_WB_ARB_RR_EN: when defined, ties in IDLE are
// resolved round-robin against last_grant; otherwise m0 always wins ties.
module psram_wb_arb #(
    parameter int unsigned TIMEOUT = 32,  // 2..255
    parameter int unsigned CNT_W   = 8    // 2**CNT_W > TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    psram_wb_arb_if.slave    m0,
    psram_wb_arb_if.slave    m1,
    psram_wb_arb_if.master   s
);

    typedef enum logic [2:0] {IDLE, GNT0, GNT1, DRAIN0, DRAIN1} state_e;

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    logic       req0, req1;
    logic       owner1, granted, connected;
    logic       tie_to_m1;
    logic       timeout;
    logic [1:0] unused_sigs;

    always_comb begin
        req0 = m0.cyc & m0.stb;
        req1 = m1.cyc & m1.stb;
        unused_sigs = {s.err, last_grant_q};
`ifdef PSRAM_WB_ARB_RR_EN
        tie_to_m1 = ~last_grant_q;
`else
        tie_to_m1 = 1'b0;
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_d         = '0;

        s.adr   = '0;
        s.dat_w = '0;
        s.sel   = '0;
        s.we    = 1'b0;
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        m0.ack  = 1'b0;
        m0.err  = 1'b0;
        m1.ack  = 1'b0;
        m1.err  = 1'b0;
        m0.dat_r = s.dat_r;
        m1.dat_r = s.dat_r;

        owner1    = (state_q == GNT1) || (state_q == DRAIN1);
        granted   = (state_q == GNT0) || (state_q == GNT1);
        connected = (state_q != IDLE);

        // Address/data/sel/we stay on the owner through DRAIN; only cyc/stb
        // are withdrawn there.
        if (connected) begin
            s.adr   = owner1 ? m1.adr   : m0.adr;
            s.dat_w = owner1 ? m1.dat_w : m0.dat_w;
            s.sel   = owner1 ? m1.sel   : m0.sel;
            s.we    = owner1 ? m1.we    : m0.we;
        end
        if (granted) begin
            s.cyc = owner1 ? m1.cyc : m0.cyc;
            s.stb = owner1 ? m1.stb : m0.stb;
        end

        // Ack in the limit cycle wins over the timeout.
        timeout = s.cyc && s.stb && !s.ack && (wd_q == WD_LIMIT);
        if (s.stb && !s.ack && !timeout) begin
            wd_d = wd_q + 1'b1;
        end

        if (granted) begin
            if (owner1) begin
                m1.ack = s.ack;
                m1.err = timeout;
            end else begin
                m0.ack = s.ack;
                m0.err = timeout;
            end
        end

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = tie_to_m1 ? GNT1 : GNT0;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end else if (timeout) begin
                    state_d = DRAIN0;
                end
            end
            GNT1: begin
                if (!m1.cyc) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end else if (timeout) begin
                    state_d = DRAIN1;
                end
            end
            DRAIN0: begin
                if (!m0.cyc) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            DRAIN1: begin
                if (!m1.cyc) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
        end
    end

endmodule

// File: tb/tb_psram_wb_arb.sv
module tb_psram_wb_arb;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic [31:0] adr;
    } req_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] dat;
        logic [31:0] adr;
        logic        ack0;
        logic        err0;
        logic        ack1;
        logic        err1;
    } exp_t;

    typedef struct {
        string       nm;
        req_t        m0;
        req_t        m1;
        logic        ack;
        logic [15:0] rdat;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic rr_build;

    psram_wb_arb_if m0_bus ();
    psram_wb_arb_if m1_bus ();
    psram_wb_arb_if s_bus ();

    psram_wb_arb #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus)
    );

    always #5 clk = ~clk;

    function automatic req_t rq(logic we, logic [1:0] sel, logic [15:0] dat,
                                logic [31:0] adr, logic stb = 1'b1);
        req_t r;
        r.cyc = 1'b1;
        r.stb = stb;
        r.we  = we;
        r.sel = sel;
        r.dat = dat;
        r.adr = adr;
        return r;
    endfunction

    // Expected slave-side view when master r is connected and granted.
    function automatic exp_t fwd(req_t r, logic a0, logic e0, logic a1, logic e1);
        exp_t e;
        e.cyc  = r.cyc;
        e.stb  = r.stb;
        e.we   = r.we;
        e.sel  = r.sel;
        e.dat  = r.dat;
        e.adr  = r.adr;
        e.ack0 = a0;
        e.err0 = e0;
        e.ack1 = a1;
        e.err1 = e1;
        return e;
    endfunction

    // Drained owner: bus fields held, cyc/stb withdrawn, no ack/err.
    function automatic exp_t drn(req_t r);
        exp_t e;
        e = fwd(r, 1'b0, 1'b0, 1'b0, 1'b0);
        e.cyc = 1'b0;
        e.stb = 1'b0;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_inputs(req_t a, req_t b, logic ack, logic [15:0] rd);
        m0_bus.cyc = a.cyc; m0_bus.stb = a.stb; m0_bus.we = a.we;
        m0_bus.sel = a.sel; m0_bus.dat_w = a.dat; m0_bus.adr = a.adr;
        m1_bus.cyc = b.cyc; m1_bus.stb = b.stb; m1_bus.we = b.we;
        m1_bus.sel = b.sel; m1_bus.dat_w = b.dat; m1_bus.adr = b.adr;
        s_bus.ack   = ack;
        s_bus.dat_r = rd;
    endtask

    task automatic chk_all(string nm, exp_t e, logic [15:0] rd);
        chk({nm, ".s_cyc"}, 32'(s_bus.cyc),   32'(e.cyc));
        chk({nm, ".s_stb"}, 32'(s_bus.stb),   32'(e.stb));
        chk({nm, ".s_we"},  32'(s_bus.we),    32'(e.we));
        chk({nm, ".s_sel"}, 32'(s_bus.sel),   32'(e.sel));
        chk({nm, ".s_dat"}, 32'(s_bus.dat_w), 32'(e.dat));
        chk({nm, ".s_adr"}, s_bus.adr,        e.adr);
        chk({nm, ".m0_ack"}, 32'(m0_bus.ack), 32'(e.ack0));
        chk({nm, ".m0_err"}, 32'(m0_bus.err), 32'(e.err0));
        chk({nm, ".m1_ack"}, 32'(m1_bus.ack), 32'(e.ack1));
        chk({nm, ".m1_err"}, 32'(m1_bus.err), 32'(e.err1));
        chk({nm, ".m0_dat"}, 32'(m0_bus.dat_r), 32'(rd));
        chk({nm, ".m1_dat"}, 32'(m1_bus.dat_r), 32'(rd));
    endtask

    // One bus cycle: inputs applied after the falling edge, outputs checked
    // 1 time unit later, well before the next rising edge.
    task automatic step(string nm, req_t a, req_t b, logic ack,
                        logic [15:0] rd, exp_t e);
        @(negedge clk);
        rst = 1'b0;
        set_inputs(a, b, ack, rd);
        #1;
        chk_all(nm, e, rd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_inputs('0, '0, 1'b0, 16'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t  vt[$];
        req_t  N, R0, W1, W1i, W2, A, B, T, Tn, S1;
        exp_t  Z;
        logic  last, g;

`ifdef PSRAM_WB_ARB_RR_EN
        rr_build = 1'b1;
`else
        rr_build = 1'b0;
`endif
        N   = '0;
        Z   = '0;
        R0  = rq(1'b0, 2'b11, 16'h0000, 32'h0000_0010);
        W1  = rq(1'b1, 2'b01, 16'h1234, 32'h0000_0020);
        W1i = rq(1'b1, 2'b01, 16'h1234, 32'h0000_0020, 1'b0);
        W2  = rq(1'b1, 2'b11, 16'h5678, 32'h0000_0024);
        A   = rq(1'b0, 2'b11, 16'h0000, 32'h0000_0100);
        B   = rq(1'b0, 2'b11, 16'h0000, 32'h0000_0200);
        T   = rq(1'b0, 2'b11, 16'h0000, 32'h0000_0300);
        Tn  = rq(1'b0, 2'b11, 16'h0000, 32'h0000_0300, 1'b0);
        S1  = rq(1'b0, 2'b10, 16'h0000, 32'h0000_0400);

        s_bus.err = 1'b0;
        set_inputs(R0, N, 1'b0, 16'h0);

        // m0 read with 6-cycle slave latency, then m1 locked over two writes
        // while m0 waits for the bus.
        vt.push_back('{"rd_idle", R0, N, 1'b0, 16'h0, Z});
        for (int i = 0; i < 5; i++)
            vt.push_back('{"rd_wait", R0, N, 1'b0, 16'h0, fwd(R0, 0, 0, 0, 0)});
        vt.push_back('{"rd_ack",   R0, N,   1'b1, 16'hBEEF, fwd(R0, 1, 0, 0, 0)});
        vt.push_back('{"rd_end",   N,  N,   1'b0, 16'h0, Z});
        vt.push_back('{"lk_idle",  N,  W1,  1'b0, 16'h0, Z});
        vt.push_back('{"lk_w1",    R0, W1,  1'b0, 16'h0, fwd(W1, 0, 0, 0, 0)});
        vt.push_back('{"lk_w1ack", R0, W1,  1'b1, 16'h0, fwd(W1, 0, 0, 1, 0)});
        vt.push_back('{"lk_gap",   R0, W1i, 1'b0, 16'h0, fwd(W1i, 0, 0, 0, 0)});
        vt.push_back('{"lk_w2",    R0, W2,  1'b0, 16'h0, fwd(W2, 0, 0, 0, 0)});
        vt.push_back('{"lk_w2ack", R0, W2,  1'b1, 16'h0, fwd(W2, 0, 0, 1, 0)});
        vt.push_back('{"lk_rel",   R0, N,   1'b0, 16'h0, Z});
        vt.push_back('{"lk_dead",  R0, N,   1'b0, 16'h0, Z});
        vt.push_back('{"lk_m0",    R0, N,   1'b1, 16'h0A0A, fwd(R0, 1, 0, 0, 0)});
        vt.push_back('{"lk_m0end", N,  N,   1'b0, 16'h0, Z});
        vt.push_back('{"lk_idle2", N,  N,   1'b0, 16'h0, Z});

        // Reset state, checked while m0 is already requesting.
        repeat (3) @(negedge clk);
        #1;
        chk_all("reset", Z, 16'h0);

        foreach (vt[i])
            step(vt[i].nm, vt[i].m0, vt[i].m1, vt[i].ack, vt[i].rdat, vt[i].e);

        // Four tie rounds; the winner drops cyc after one acked transfer and
        // re-raises in the dead cycle.
        do_reset();
        last = 1'b1;
        g    = 1'b0;
        for (int r = 0; r < 4; r++) begin
            g = rr_build ? ~last : 1'b0;
            step("tie_idle", A, B, 1'b0, 16'h0, Z);
            step("tie_gnt",  A, B, 1'b1, 16'(16'h1111 * (r + 1)),
                 g ? fwd(B, 0, 0, 1, 0) : fwd(A, 1, 0, 0, 0));
            step("tie_rel",  g ? A : N, g ? N : B, 1'b0, 16'h0, Z);
            last = g;
        end
        // Only the last round's loser keeps requesting.
        step("tie_fin_idle", g ? A : N, g ? N : B, 1'b0, 16'h0, Z);
        step("tie_fin",      g ? A : N, g ? N : B, 1'b1, 16'h7777,
             g ? fwd(A, 1, 0, 0, 0) : fwd(B, 0, 0, 1, 0));
        step("tie_fin_end",  N, N, 1'b0, 16'h0, Z);
        step("tie_quiet",    N, N, 1'b0, 16'h0, Z);

        // Slave never acks (TIMEOUT = 8): err in the 8th strobed cycle.
        step("to_idle", T, N, 1'b0, 16'h0, Z);
        for (int i = 0; i < 7; i++)
            step("to_wait", T, N, 1'b0, 16'h0, fwd(T, 0, 0, 0, 0));
        step("to_err",    T, N,  1'b0, 16'h0, fwd(T, 0, 1, 0, 0));
        step("to_drain",  T, S1, 1'b0, 16'h0, drn(T));
        step("to_drain2", T, S1, 1'b1, 16'h0, drn(T));
        step("to_drop",   N, S1, 1'b0, 16'h0, Z);
        step("to_dead",   N, S1, 1'b0, 16'h0, Z);
        step("to_m1",     N, S1, 1'b1, 16'h0, fwd(S1, 0, 0, 1, 0));
        step("to_m1end",  N, N,  1'b0, 16'h0, Z);

        // Ack in the same cycle the watchdog reaches TIMEOUT-1.
        step("ta_idle", T, N, 1'b0, 16'h0, Z);
        for (int i = 0; i < 7; i++)
            step("ta_wait", T, N, 1'b0, 16'h0, fwd(T, 0, 0, 0, 0));
        step("ta_ack",  T,  N, 1'b1, 16'h5A5A, fwd(T, 1, 0, 0, 0));
        step("ta_hold", Tn, N, 1'b0, 16'h0, fwd(Tn, 0, 0, 0, 0));
        step("ta_end",  N,  N, 1'b0, 16'h0, Z);

        // Reset while m1 owns the bus, then a tie right after release.
        step("rs_idle", N, S1, 1'b0, 16'h0, Z);
        step("rs_gnt",  N, S1, 1'b0, 16'h0, fwd(S1, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        step("rs_after", A, S1, 1'b1, 16'h3C3C, Z);
        step("rs_tie",   A, S1, 1'b0, 16'h0, fwd(A, 0, 0, 0, 0));
        step("rs_end",   N, N,  1'b0, 16'h0, Z);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
